// File: rtl/mem_access_unit.sv
// MEM pipeline stage: bus request/ack handshake to the data-bus arbiter,
// byte-lane steering for stores, load extension, alignment and bus error flags.
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        writeAddr_i,
  input  logic              writeEnable_i,
  input  logic [1:0]        writeHILO_i,
  input  logic [31:0]       HI_data_i,
  input  logic [31:0]       LO_data_i,
  input  logic [31:0]       storeData_i,
  input  logic [3:0]        ramOp_i,
  output logic [4:0]        writeAddr_o,
  output logic              writeEnable_o,
  output logic [1:0]        writeHILO_o,
  output logic [31:0]       HI_data_o,
  output logic [31:0]       LO_data_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_be_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              excAddrErr_o,
  output logic              excBusErr_o,
  output logic              pauseRequest
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;

  // Timer only needs to reach TIMEOUT; a 1-bit stub when timeouts are disabled.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [3:0]    op_q;
  logic [1:0]    lane_q;
  logic          half_q;

  logic          op_load, op_store, op_valid, misaligned, issue, timeout_hit;
  logic [1:0]    lane;
  logic          half_hi;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  // Decode the incoming op: class, alignment, lane selection and store data steering.
  always_comb begin
    op_load  = (ramOp_i >= OP_LB) && (ramOp_i <= OP_LW);
    op_store = (ramOp_i >= OP_SB) && (ramOp_i <= OP_SW);
    op_valid = op_load || op_store;
    misaligned = 1'b0;
    be_d     = 4'h0;
    wdata_d  = 32'h0;
    // Big-endian mirrors lane k to 3-k, which for a 2-bit index is ~k.
    lane     = BIG_ENDIAN ? ~LO_data_i[1:0] : LO_data_i[1:0];
    half_hi  = BIG_ENDIAN ? ~LO_data_i[1] : LO_data_i[1];
    case (ramOp_i)
      OP_LB, OP_LBU: be_d = 4'b0001 << lane;
      OP_SB: begin
        be_d    = 4'b0001 << lane;
        wdata_d = {4{storeData_i[7:0]}};
      end
      OP_LH, OP_LHU: begin
        be_d       = half_hi ? 4'hC : 4'h3;
        misaligned = LO_data_i[0];
      end
      OP_SH: begin
        be_d       = half_hi ? 4'hC : 4'h3;
        wdata_d    = {2{storeData_i[15:0]}};
        misaligned = LO_data_i[0];
      end
      OP_LW: begin
        be_d       = 4'hF;
        misaligned = |LO_data_i[1:0];
      end
      OP_SW: begin
        be_d       = 4'hF;
        wdata_d    = storeData_i;
        misaligned = |LO_data_i[1:0];
      end
      default: ;
    endcase
  end

  // Extend the captured read data using the op and lane recorded at issue time.
  always_comb begin
    ld_byte = rdata_q[{lane_q, 3'b000} +: 8];
    ld_half = half_q ? rdata_q[31:16] : rdata_q[15:0];
    case (op_q)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'h0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'h0, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state, stall request, exception flags and write-back pass-through.
  always_comb begin
    state_n       = state;
    issue         = 1'b0;
    pauseRequest  = 1'b0;
    excAddrErr_o  = 1'b0;
    excBusErr_o   = 1'b0;
    writeAddr_o   = writeAddr_i;
    writeEnable_o = writeEnable_i;
    writeHILO_o   = writeHILO_i;
    HI_data_o     = HI_data_i;
    LO_data_o     = LO_data_i;
    case (state)
      S_IDLE: begin
        if (op_valid && misaligned) begin
          excAddrErr_o  = 1'b1;
          writeEnable_o = 1'b0;
        end else if (op_valid) begin
          issue        = 1'b1;
          pauseRequest = 1'b1;
          state_n      = S_WAIT;
        end
      end
      S_WAIT: begin
        pauseRequest = 1'b1;
        if (bus_err_i || bus_ack_i || timeout_hit) state_n = S_DONE;
      end
      S_DONE: begin
        excBusErr_o = err_q;
        if (err_q)          writeEnable_o = 1'b0;
        else if (op_q >= OP_LB && op_q <= OP_LW) LO_data_o = ld_ext;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (rst) begin
      state_n       = S_IDLE;
      issue         = 1'b0;
      pauseRequest  = 1'b0;
      excAddrErr_o  = 1'b0;
      excBusErr_o   = 1'b0;
      writeAddr_o   = 5'h0;
      writeEnable_o = 1'b0;
      writeHILO_o   = 2'h0;
      HI_data_o     = 32'h0;
      LO_data_o     = 32'h0;
    end
  end

  // Bus request registers, wait timer and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= 4'h0;
      bus_addr_o  <= '0;
      bus_wdata_o <= 32'h0;
      timer       <= '0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      op_q        <= 4'h0;
      lane_q      <= 2'h0;
      half_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= op_store;
            bus_be_o    <= be_d;
            bus_addr_o  <= {LO_data_i[ADDR_W-1:2], 2'b00};
            bus_wdata_o <= wdata_d;
            timer       <= '0;
            err_q       <= 1'b0;
            op_q        <= ramOp_i;
            lane_q      <= lane;
            half_q      <= half_hi;
          end
        end
        S_WAIT: begin
          // Error wins over a simultaneous ack; timeout only if neither arrived.
          if (bus_err_i) begin
            bus_req_o <= 1'b0;
            err_q     <= 1'b1;
          end else if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            rdata_q   <= bus_rdata_i;
          end else if (timeout_hit) begin
            bus_req_o <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit: little- and big-endian
// instances share stimulus and are checked against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  writeAddr_i;
  logic        writeEnable_i;
  logic [1:0]  writeHILO_i;
  logic [31:0] HI_data_i, LO_data_i, storeData_i, bus_rdata_i;
  logic [3:0]  ramOp_i;
  logic        bus_ack_i, bus_err_i;

  logic [4:0]  wa_a, wa_b;
  logic        we_a, we_b;
  logic [1:0]  hl_a, hl_b;
  logic [31:0] hi_a, hi_b, lo_a, lo_b;
  logic        req_a, req_b, bwe_a, bwe_b;
  logic [3:0]  be_a, be_b;
  logic [31:0] addr_a, addr_b, wd_a, wd_b;
  logic        ae_a, ae_b, be_err_a, be_err_b, p_a, p_b;

  int n_chk  = 0;
  int n_pass = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst(rst), .writeAddr_i(writeAddr_i), .writeEnable_i(writeEnable_i),
    .writeHILO_i(writeHILO_i), .HI_data_i(HI_data_i), .LO_data_i(LO_data_i),
    .storeData_i(storeData_i), .ramOp_i(ramOp_i), .writeAddr_o(wa_a), .writeEnable_o(we_a),
    .writeHILO_o(hl_a), .HI_data_o(hi_a), .LO_data_o(lo_a), .bus_req_o(req_a),
    .bus_we_o(bwe_a), .bus_be_o(be_a), .bus_addr_o(addr_a), .bus_wdata_o(wd_a),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i),
    .excAddrErr_o(ae_a), .excBusErr_o(be_err_a), .pauseRequest(p_a));

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .writeAddr_i(writeAddr_i), .writeEnable_i(writeEnable_i),
    .writeHILO_i(writeHILO_i), .HI_data_i(HI_data_i), .LO_data_i(LO_data_i),
    .storeData_i(storeData_i), .ramOp_i(ramOp_i), .writeAddr_o(wa_b), .writeEnable_o(we_b),
    .writeHILO_o(hl_b), .HI_data_o(hi_b), .LO_data_o(lo_b), .bus_req_o(req_b),
    .bus_we_o(bwe_b), .bus_be_o(be_b), .bus_addr_o(addr_b), .bus_wdata_o(wd_b),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i),
    .excAddrErr_o(ae_b), .excBusErr_o(be_err_b), .pauseRequest(p_b));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_valid(input int op);
    return op >= 1 && op <= 8;
  endfunction

  function automatic bit m_load_op(input int op);
    return op >= 1 && op <= 5;
  endfunction

  function automatic bit m_mis(input int op, input logic [31:0] a);
    if (op == 3 || op == 4 || op == 7) return (a % 2) != 0;
    if (op == 5 || op == 8) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_be(input int op, input logic [31:0] a, input bit big);
    int k, h;
    k = int'(a % 4);
    h = int'(a % 4) - int'(a % 2);
    if (op == 1 || op == 2 || op == 6) return 1 << (big ? 3 - k : k);
    if (op == 3 || op == 4 || op == 7) return 3 << (big ? 2 - h : h);
    if (op == 5 || op == 8) return 15;
    return 0;
  endfunction

  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] sd);
    if (op == 6) return (sd & 32'hFF) * 32'h01010101;
    if (op == 7) return (sd & 32'hFFFF) * 32'h00010001;
    if (op == 8) return sd;
    return 0;
  endfunction

  function automatic logic [31:0] m_load(input int op, input logic [31:0] a,
                                         input logic [31:0] rd, input bit big);
    logic [31:0] v;
    int k, h;
    k = int'(a % 4);
    h = int'(a % 4) - int'(a % 2);
    if (op == 1 || op == 2) begin
      v = (rd >> (8 * (big ? 3 - k : k))) & 32'hFF;
      if (op == 1 && v >= 128) v = v - 32'd256;
      return v;
    end
    if (op == 3 || op == 4) begin
      v = (rd >> (8 * (big ? 2 - h : h))) & 32'hFFFF;
      if (op == 3 && v >= 32768) v = v - 32'd65536;
      return v;
    end
    return rd;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One access; mode 0=ack, 1=err, 2=ack+err together, 3=no response (timeout).
  task automatic access(input int op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int nwait, input int mode);
    bit err, last, done;
    err  = (mode != 0);
    done = 1'b0;
    ramOp_i       = 4'(op);
    LO_data_i     = a;
    storeData_i   = sd;
    writeEnable_i = 1'b1;
    writeAddr_i   = 5'($urandom);
    writeHILO_i   = 2'($urandom);
    HI_data_i     = $urandom;
    @(negedge clk);
    chk("pass_waddr", wa_a, writeAddr_i);
    chk("pass_hilo", hl_a, writeHILO_i);
    chk("pass_hi", hi_b, HI_data_i);
    chk("idle_req", req_a, 0);
    if (!m_valid(op)) begin
      chk("nop_pause", p_a, 0);
      chk("nop_we", we_a, 1);
      chk("nop_lo", lo_a, a);
      chk("nop_aerr", ae_a, 0);
      @(posedge clk); #1;
      return;
    end
    if (m_mis(op, a)) begin
      chk("mis_aerr", ae_a, 1);
      chk("mis_aerr_be", ae_b, 1);
      chk("mis_we", we_a, 0);
      chk("mis_pause", p_a, 0);
      @(posedge clk); #1;
      ramOp_i = 4'd0;
      @(negedge clk);
      chk("mis_noreq", req_a, 0);
      chk("mis_noreq_be", req_b, 0);
      @(posedge clk); #1;
      return;
    end
    chk("idle_pause", p_a, 1);
    chk("idle_aerr", ae_a, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      last = (mode == 3) ? (i == TO) : (i == nwait);
      if (last && mode != 3) begin
        bus_ack_i   = (mode != 1);
        bus_err_i   = 1'b1 && (mode != 0);
        bus_rdata_i = rd;
      end
      @(negedge clk);
      chk("wait_req", req_a, 1);
      chk("wait_req_be", req_b, 1);
      chk("wait_pause", p_a, 1);
      chk("wait_we", bwe_a, (op >= 6) ? 1 : 0);
      chk("wait_addr", addr_a, a & ~32'h3);
      chk("wait_be_le", be_a, m_be(op, a, 1'b0));
      chk("wait_be_be", be_b, m_be(op, a, 1'b1));
      if (op >= 6) begin
        chk("wait_wdata", wd_a, m_wdata(op, sd));
        chk("wait_wdata_be", wd_b, m_wdata(op, sd));
      end
      @(posedge clk); #1;
      bus_ack_i   = 1'b0;
      bus_err_i   = 1'b0;
      bus_rdata_i = $urandom;
      if (last) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("wait_bound", 0, 1);
    @(negedge clk);
    chk("done_req", req_a, 0);
    chk("done_pause", p_a, 0);
    chk("done_berr", be_err_a, err);
    chk("done_berr_be", be_err_b, err);
    chk("done_we", we_a, err ? 0 : 1);
    if (m_load_op(op) && !err) begin
      chk("load_le", lo_a, m_load(op, a, rd, 1'b0));
      chk("load_be", lo_b, m_load(op, a, rd, 1'b1));
    end
    @(posedge clk); #1;
    ramOp_i = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ramOp_i = 4'd5; LO_data_i = 32'h100; storeData_i = 32'h1234; writeEnable_i = 1'b1;
    writeAddr_i = 5'd7; writeHILO_i = 2'd3; HI_data_i = 32'hCAFE; bus_rdata_i = 32'h0;
    bus_ack_i = 1'b0; bus_err_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pause", p_a, 0);
    chk("rst_we", we_a, 0);
    chk("rst_lo", lo_a, 0);
    chk("rst_hi", hi_a, 0);
    chk("rst_waddr", wa_a, 0);
    chk("rst_req", req_a, 0);
    chk("rst_be", be_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_wdata", wd_a, 0);
    chk("rst_bwe", bwe_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ramOp_i = 4'd0;
    @(posedge clk); #1;

    access(5, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0);   // LW, two wait states
    access(1, 32'h103, 32'h0, 32'h80112233, 0, 0);   // LB
    access(2, 32'h103, 32'h0, 32'h80112233, 1, 0);   // LBU
    access(7, 32'h102, 32'h0000ABCD, 32'h0, 1, 0);   // SH
    access(5, 32'h101, 32'h0, 32'h0, 0, 0);          // misaligned LW
    access(5, 32'h100, 32'h0, 32'h0, 0, 3);          // timeout
    access(8, 32'h104, 32'h55AA55AA, 32'h0, 1, 2);   // ack+err together
    access(3, 32'h106, 32'h0, 32'h8001F00F, 0, 1);   // bus error on a load

    // Reset during WAIT, then a late ack in IDLE.
    ramOp_i = 4'd5; LO_data_i = 32'h200; writeEnable_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_req", req_a, 1);
    rst = 1'b1;
    ramOp_i = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_req_drop", req_a, 0);
    chk("rw_pause", p_a, 0);
    @(posedge clk); #1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
    @(negedge clk);
    chk("late_ack_req", req_a, 0);
    chk("late_ack_pause", p_a, 0);
    chk("late_ack_berr", be_err_a, 0);
    chk("late_ack_lo", lo_a, 32'h200);
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_lo2", lo_a, 32'h200);
    chk("late_ack_req2", req_a, 0);
    @(posedge clk); #1;

    for (int t = 0; t < 80; t++) begin
      int op, mode, nw;
      logic [31:0] a;
      op   = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = int'($urandom_range(1, 8));
      a    = 32'h1000 + ($urandom & 32'hFF);
      nw   = int'($urandom_range(0, TO - 1));
      mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      access(op, a, $urandom, $urandom, nw, mode);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
